rec_net_psum_accum: RTL
=======================

# rec_net_psum_accum

Downstream partial-sum accumulator for the multi-core multiply tree. Consumes the per-core `2*WORD_SIZE` dot-product results, accumulates them over a programmable number of passes (tiles of a longer reduction) into wide per-core accumulators, and hands each finished result vector to the next stage over a valid/ready handshake. It holds one accumulating tile and one completed result, so output back-pressure stalls the input stream only after a second tile completes.

## Interface
- `NUM_CORES`, 4, number of core lanes in `psum_in`/`acc_out`
- `WORD_SIZE`, 8, core operand width; each input lane is `2*WORD_SIZE` bits
- `ACC_WIDTH`, 24, per-lane accumulator width; must be ≥ `2*WORD_SIZE`
- `PASS_CNT_W`, 8, width of the pass count and pass counter

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_num_passes`  in  PASS_CNT_W  passes per tile; 0 treated as 1; sampled on the first accepted beat of each tile
- `psum_valid`  in  1  `psum_in` carries a valid core result this cycle
- `psum_ready`  out  1  block accepts a beat this cycle
- `psum_in`  in  2*NUM_CORES*WORD_SIZE  lane c at bits `[(c+1)*2*WORD_SIZE-1 -: 2*WORD_SIZE]`, signed two's complement
- `acc_out_valid`  out  1  `acc_out` holds a completed tile
- `acc_out_ready`  in  1  consumer takes `acc_out` this cycle
- `acc_out`  out  NUM_CORES*ACC_WIDTH  lane c at bits `[(c+1)*ACC_WIDTH-1 -: ACC_WIDTH]`, signed
- `ovf_err`  out  1  sticky: a beat arrived while `psum_ready` was low

## Operation
- States: `ACCUM` (psum_ready=1), `HOLD` (psum_ready=0). Reset state `ACCUM`, pass counter 0.
- Beat accepted when `psum_valid && psum_ready`. Each lane sign-extended to `ACC_WIDTH`.
- First beat of tile (counter 0): acc ← sext(in); latch N = max(cfg_num_passes,1). Later beats: acc ← acc + sext(in). Counter increments per beat.
- Final beat (counter reaches N; N=1 makes the first beat final): completed value = new acc; counter → 0.
  - Output register empty, or draining this cycle (`acc_out_valid && acc_out_ready`): completed value → `acc_out`, `acc_out_valid`=1 next cycle; stay `ACCUM`.
  - Otherwise: completed value stays in acc, go `HOLD`.
- `HOLD`: on output handshake, acc → `acc_out` (valid stays 1), return to `ACCUM`. `psum_ready` is 1 the following cycle.
- Output handshake with nothing new to load: `acc_out_valid` → 0.
- `acc_out` stable while `acc_out_valid && !acc_out_ready`.
- `psum_valid` while `psum_ready`=0: beat dropped, `ovf_err` ← 1; cleared only by `rst`.
- `rst` mid-tile or mid-HOLD: partial and held data discarded, no output generated.

## Timing
- After reset: `acc_out_valid`=0, `acc_out`=0, `ovf_err`=0, `psum_ready`=1, counter 0.
- Latency: final accepted beat at edge k → `acc_out_valid`=1 after edge k+1.
- Throughput: one beat per cycle; back-to-back tiles with no bubble while the consumer keeps `acc_out_ready` high.
- `psum_ready` is a registered state decode (no combinational path from `acc_out_ready`).
- `cfg_num_passes` changes mid-tile have no effect until the next tile.

## Configuration
- `PSUM_ACC_SAT_EN` defined: each add saturates to the signed `ACC_WIDTH` range (max `2^(ACC_WIDTH-1)-1`, min `-2^(ACC_WIDTH-1)`); the sticky saturation state per tile is not exported.
- Undefined: adds wrap modulo `2^ACC_WIDTH`.

## Test plan
- N=1, beats lane0 = 0x0005, 0xFFFE, acc_out_ready=1 → `acc_out` lane0 = 5 then −2 (0xFFFFFE), on consecutive cycles, valid held high.
- N=3, lane values 100, −50, 7 on all 4 lanes → one output, each lane 57, valid one cycle after third beat.
- acc_out_ready=0, N=1, three consecutive beats 1,2,3 → out=1, acc holds 2, psum_ready low; third beat dropped, `ovf_err`=1; ready high → 1 then 2 delivered.
- ACC_WIDTH=16, N=4, lane 0x7FFF each beat → with `PSUM_ACC_SAT_EN` 0x7FFF; without, 0xFFFC.
- `rst` after 2 of 3 passes, then full 3-pass tile of 1s → only output is 3; all outputs at reset values for the cycle after `rst`.
- cfg_num_passes=0 → each beat is its own tile, matches N=1 behaviour.

Source files
------------

// File: rtl/rec_net_psum_accum.sv
// Partial-sum accumulator: folds per-core dot-product results over N passes and
// hands finished tiles downstream. Optional macro PSUM_ACC_SAT_EN selects saturating adds.
module rec_net_psum_accum #(
  parameter int NUM_CORES  = 4,
  parameter int WORD_SIZE  = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int PASS_CNT_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PASS_CNT_W-1:0]             cfg_num_passes,
  input  logic                              psum_valid,
  output logic                              psum_ready,
  input  logic [2*NUM_CORES*WORD_SIZE-1:0]  psum_in,
  output logic                              acc_out_valid,
  input  logic                              acc_out_ready,
  output logic [NUM_CORES*ACC_WIDTH-1:0]    acc_out,
  output logic                              ovf_err
);

  localparam int LW = 2 * WORD_SIZE;

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_e;

  state_e                                state_q, state_d;
  logic [PASS_CNT_W-1:0]                 cnt_q, cnt_d;
  logic [PASS_CNT_W-1:0]                 n_q, n_d;
  logic [NUM_CORES-1:0][ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [NUM_CORES-1:0][ACC_WIDTH-1:0]   out_q, out_d;
  logic                                  out_valid_q, out_valid_d;
  logic                                  ovf_q, ovf_d;

  logic                                  accept_s;
  logic                                  drain_s;
  logic                                  first_s;
  logic                                  final_s;
  logic [PASS_CNT_W-1:0]                 n_eff_s;
  logic [PASS_CNT_W:0]                   cnt_inc_s;
  logic [NUM_CORES-1:0][ACC_WIDTH-1:0]   acc_new_s;

  function automatic logic [ACC_WIDTH-1:0] sext(input logic [LW-1:0] x);
    return ACC_WIDTH'($signed(x));
  endfunction

  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH-1:0] sum;
    sum = a + b;
`ifdef PSUM_ACC_SAT_EN
    // Same-sign operands producing an opposite-sign sum have overflowed: clamp.
    if ((a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != a[ACC_WIDTH-1])) begin
      sum = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sum = sum;
    end
`else
    sum = sum;
`endif
    return sum;
  endfunction

  assign psum_ready    = (state_q == ACCUM);
  assign acc_out_valid = out_valid_q;
  assign acc_out       = out_q;
  assign ovf_err       = ovf_q;

  assign accept_s  = psum_valid && (state_q == ACCUM);
  assign drain_s   = out_valid_q && acc_out_ready;
  assign first_s   = (cnt_q == {PASS_CNT_W{1'b0}});
  assign n_eff_s   = first_s ? ((cfg_num_passes == {PASS_CNT_W{1'b0}}) ? PASS_CNT_W'(1) : cfg_num_passes)
                             : n_q;
  assign cnt_inc_s = {1'b0, cnt_q} + {{PASS_CNT_W{1'b0}}, 1'b1};
  assign final_s   = accept_s && (cnt_inc_s == {1'b0, n_eff_s});

  // Per-lane value the accumulator would take if this cycle's beat is accepted.
  always_comb begin
    acc_new_s = acc_q;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (first_s) begin
        acc_new_s[c] = sext(psum_in[c*LW +: LW]);
      end else begin
        acc_new_s[c] = acc_add(acc_q[c], sext(psum_in[c*LW +: LW]));
      end
    end
  end

  // Next-state logic: accumulate, complete tiles, hand off or park in HOLD.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q | (psum_valid && (state_q == HOLD));
    case (state_q)
      ACCUM: begin
        if (accept_s) begin
          acc_d = acc_new_s;
          n_d   = n_eff_s;
          cnt_d = final_s ? {PASS_CNT_W{1'b0}} : cnt_inc_s[PASS_CNT_W-1:0];
        end else begin
          acc_d = acc_q;
        end
        if (final_s) begin
          if (!out_valid_q || drain_s) begin
            out_d       = acc_new_s;
            out_valid_d = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end else if (drain_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      HOLD: begin
        // Completed tile waits in acc until the output register frees up.
        if (drain_s) begin
          out_d       = acc_q;
          out_valid_d = 1'b1;
          state_d     = ACCUM;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= {PASS_CNT_W{1'b0}};
      n_q         <= {PASS_CNT_W{1'b0}};
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule
